// File: rtl/freq_gen_pkg.sv
// Shared constants and types for the freq_gen_nco waveform generator.
package freq_gen_pkg;

  localparam int unsigned DEFAULT_ACC_W = 32;
  localparam int unsigned DEFAULT_CNT_W = 32;
  localparam int unsigned AVS_ADDR_W    = 3;
  localparam int unsigned AVS_DATA_W    = 32;

  // Avalon-MM register map
  localparam logic [AVS_ADDR_W-1:0] ADDR_CTRL   = 3'd0;
  localparam logic [AVS_ADDR_W-1:0] ADDR_FTW    = 3'd1;
  localparam logic [AVS_ADDR_W-1:0] ADDR_DUTY   = 3'd2;
  localparam logic [AVS_ADDR_W-1:0] ADDR_BURST  = 3'd3;
  localparam logic [AVS_ADDR_W-1:0] ADDR_STATUS = 3'd4;
  localparam logic [AVS_ADDR_W-1:0] ADDR_PCOUNT = 3'd5;

  // Register bit positions
  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned STAT_BUSY_BIT = 0;
  localparam int unsigned STAT_DONE_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic done;
    logic busy;
  } status_t;

  // Pack the status flags into a read word at their documented bit positions.
  function automatic logic [AVS_DATA_W-1:0] status_word(input status_t s);
    logic [AVS_DATA_W-1:0] w;
    w                = '0;
    w[STAT_BUSY_BIT] = s.busy;
    w[STAT_DONE_BIT] = s.done;
    return w;
  endfunction

endpackage

// File: rtl/freq_gen_nco_core.sv
// Phase accumulator with carry-based period detection, duty compare and
// boundary-synchronous reload of the active FTW/DUTY registers.
import freq_gen_pkg::*;

module freq_gen_nco_core #(
  parameter int unsigned ACC_W = DEFAULT_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             run_i,
  input  logic [ACC_W-1:0] ftw_stg_i,
  input  logic [ACC_W-1:0] duty_stg_i,
  output logic             boundary_c_o,
  output logic             below_duty_c_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] ftw_act_q, ftw_act_d;
  logic [ACC_W-1:0] duty_act_q, duty_act_d;
  logic [ACC_W:0]   sum_c;

  // Next accumulator value; active registers only change on start or a carry.
  always_comb begin
    sum_c        = {1'b0, acc_q} + {1'b0, ftw_act_q};
    acc_d        = '0;
    ftw_act_d    = ftw_act_q;
    duty_act_d   = duty_act_q;
    boundary_c_o = 1'b0;
    if (start_i) begin
      ftw_act_d  = ftw_stg_i;
      duty_act_d = duty_stg_i;
    end else if (run_i) begin
      acc_d        = sum_c[ACC_W-1:0];
      boundary_c_o = sum_c[ACC_W];
      if (sum_c[ACC_W]) begin
        ftw_act_d  = ftw_stg_i;
        duty_act_d = duty_stg_i;
      end
    end
  end

  assign below_duty_c_o = (acc_q < duty_act_q);

  // Accumulator and active-register storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q      <= '0;
      ftw_act_q  <= '0;
      duty_act_q <= '0;
    end else begin
      acc_q      <= acc_d;
      ftw_act_q  <= ftw_act_d;
      duty_act_q <= duty_act_d;
    end
  end

endmodule

// File: rtl/freq_gen_nco.sv
// Avalon-MM programmable square/pulse generator (continuous or N-period burst).
// Optional coe_sync period-trigger output: define FREQ_GEN_SYNC_OUT_EN.
import freq_gen_pkg::*;

module freq_gen_nco #(
  parameter int unsigned ACC_W = DEFAULT_ACC_W,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic                  csi_clk,
  input  logic                  csi_reset_n,
  input  logic                  avs_chipselect,
  input  logic [AVS_ADDR_W-1:0] avs_address,
  input  logic                  avs_write,
  input  logic [AVS_DATA_W-1:0] avs_writedata,
  input  logic                  avs_read,
  output logic [AVS_DATA_W-1:0] avs_readdata,
  output logic                  coe_wave_out,
  output logic                  coe_busy
`ifdef FREQ_GEN_SYNC_OUT_EN
  ,
  output logic                  coe_sync
`endif
);

  state_e           state_q, state_d;
  logic             ctrl_q;
  logic [ACC_W-1:0] ftw_stg_q;
  logic [ACC_W-1:0] duty_stg_q;
  logic [CNT_W-1:0] burst_stg_q;
  logic [CNT_W-1:0] pcount_q, pcount_d;
  logic [CNT_W-1:0] pcount_inc_c;
  logic             done_q, done_d;
  logic             wave_q, wave_d;
  logic             busy_q, busy_d;
  logic             wr_c, ctrl_wr_c, en_c;
  logic             start_c, run_c;
  logic             boundary_c, below_duty_c;
  status_t          status_c;

  assign wr_c      = avs_chipselect && avs_write;
  assign ctrl_wr_c = wr_c && (avs_address == ADDR_CTRL);
  assign en_c      = avs_writedata[CTRL_EN_BIT];
  assign run_c     = (state_q == ST_RUN);

  freq_gen_nco_core #(
    .ACC_W (ACC_W)
  ) u_core (
    .clk            (csi_clk),
    .rst_n          (csi_reset_n),
    .start_i        (start_c),
    .run_i          (run_c),
    .ftw_stg_i      (ftw_stg_q),
    .duty_stg_i     (duty_stg_q),
    .boundary_c_o   (boundary_c),
    .below_duty_c_o (below_duty_c)
  );

  // Staging registers written by software; the core picks them up at boundaries.
  always_ff @(posedge csi_clk) begin
    if (!csi_reset_n) begin
      ctrl_q      <= 1'b0;
      ftw_stg_q   <= '0;
      duty_stg_q  <= '0;
      burst_stg_q <= '0;
    end else if (wr_c) begin
      unique case (avs_address)
        ADDR_CTRL:  ctrl_q      <= en_c;
        ADDR_FTW:   ftw_stg_q   <= avs_writedata[ACC_W-1:0];
        ADDR_DUTY:  duty_stg_q  <= avs_writedata[ACC_W-1:0];
        ADDR_BURST: burst_stg_q <= avs_writedata[CNT_W-1:0];
        default:    ;
      endcase
    end
  end

  // Next-state, period counter and output decode; abort overrides a final boundary.
  always_comb begin
    state_d      = state_q;
    done_d       = done_q;
    pcount_d     = pcount_q;
    start_c      = 1'b0;
    pcount_inc_c = pcount_q + CNT_W'(1);
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (ctrl_wr_c && en_c) begin
          state_d  = ST_RUN;
          done_d   = 1'b0;
          pcount_d = '0;
          start_c  = 1'b1;
        end else if (ctrl_wr_c && (state_q == ST_DONE)) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (boundary_c) begin
          if (!(&pcount_q)) begin
            pcount_d = pcount_inc_c;
          end
          if ((burst_stg_q != '0) && (pcount_inc_c == burst_stg_q)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        if (ctrl_wr_c && !en_c) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    wave_d = run_c && below_duty_c;
    busy_d = (state_d == ST_RUN);
  end

  // State, counter and registered conduit outputs.
  always_ff @(posedge csi_clk) begin
    if (!csi_reset_n) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      pcount_q <= '0;
      wave_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      pcount_q <= pcount_d;
      wave_q   <= wave_d;
      busy_q   <= busy_d;
    end
  end

  assign coe_wave_out = wave_q;
  assign coe_busy     = busy_q;

`ifdef FREQ_GEN_SYNC_OUT_EN
  logic bnd_q;
  logic sync_q;

  // One-clock trigger on the edge after each boundary, aligned with the new period.
  always_ff @(posedge csi_clk) begin
    if (!csi_reset_n) begin
      bnd_q  <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      bnd_q  <= boundary_c;
      sync_q <= bnd_q;
    end
  end

  assign coe_sync = sync_q;
`endif

  // Combinational read mux; unselected or unmapped reads return zero.
  always_comb begin
    status_c      = '{done: done_q, busy: busy_q};
    avs_readdata  = '0;
    if (avs_chipselect && avs_read) begin
      unique case (avs_address)
        ADDR_CTRL:   avs_readdata = AVS_DATA_W'(ctrl_q);
        ADDR_FTW:    avs_readdata = AVS_DATA_W'(ftw_stg_q);
        ADDR_DUTY:   avs_readdata = AVS_DATA_W'(duty_stg_q);
        ADDR_BURST:  avs_readdata = AVS_DATA_W'(burst_stg_q);
        ADDR_STATUS: avs_readdata = status_word(status_c);
        ADDR_PCOUNT: avs_readdata = AVS_DATA_W'(pcount_q);
        default:     avs_readdata = '0;
      endcase
    end
  end

endmodule
